mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFF00: byte address of register window, 16'b aligned.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16'd868: clk cycles per serial bit, legal range 2..65535.
REQ-003 SHALL have ports:
- clk  input  1  rising-edge clock; one clock only.
- rst  input  1  synchronous, active-high reset.
- wen  input  1  data-bus write strobe, sampled on posedge clk.
- ren  input  1  data-bus read strobe.
- addr  input  16  data-bus byte address.
- din  input  16  data-bus write data.
- dout  output  16  data-bus read data, combinational.
- tx  output  1  serial line, idle high.

Function
REQ-004 SHALL decode three 16-bit registers: DATA at BASE_ADDR+0, STATUS at BASE_ADDR+2, CTRL at BASE_ADDR+4; all other addresses are ignored.
REQ-005 SHALL, on wen to DATA with FIFO not full, push din[7:0] into a 4-entry FIFO; din[15:8] is ignored.
REQ-006 SHALL, on wen to DATA with FIFO full and no pop in the same cycle, drop the byte and set sticky OVF.
REQ-007 SHALL, on wen to DATA with FIFO full and a pop in the same cycle, accept the byte; count stays 4.
REQ-008 SHALL, on wen to STATUS, clear OVF when din[6]=1; all other STATUS bits are read-only.
REQ-009 SHALL, on wen to CTRL, latch din[0] as EN; other bits are read as 0.
REQ-010 SHALL drive dout to the following values when ren=1 and addr hits:
- DATA: 16'h0000.
- STATUS: {9'b0, OVF, count[2:0], EMPTY, FULL, BUSY}.
- CTRL: {15'b0, EN}.
REQ-011 SHALL drive dout=16'h0000 when ren=0 or addr misses.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; BUSY=1 in every state except IDLE.
REQ-013 SHALL move IDLE->START when EN=1 and FIFO is not empty, popping the FIFO head into an 8-bit shift register on that edge.
REQ-014 SHALL hold each of START, each DATA bit, PARITY, and STOP for exactly CLKS_PER_BIT cycles, using a 16-bit down-counter reloaded at every bit boundary.
REQ-015 SHALL drive tx as follows:
- START: 0.
- DATA: shift register bit 0, LSB first, 8 bits, tracked by a 3-bit bit index.
- STOP: 1.
- IDLE: 1.
REQ-016 SHALL move from STOP to START directly, with no idle cycle, when EN=1 and FIFO is not empty at the end of STOP; otherwise it SHALL move to IDLE.
REQ-017 SHALL let a frame in progress complete when EN is cleared mid-frame; no new frame starts while EN=0.
REQ-018 SHALL ensure a write in the same cycle as IDLE->START is not lost: push and pop are both applied.
REQ-019 SHALL register tx directly from a flip-flop, with no glitching combinational path.

Reset
REQ-020 SHALL, when rst=1 at posedge clk, set the following regardless of other inputs; reset mid-frame aborts the frame immediately:
- state=IDLE.
- FIFO count=0 and read/write pointers=0.
- OVF=0.
- EN=0.
- bit counter=0.
- tx=1.
REQ-021 SHALL give reset priority over a simultaneous wen.
REQ-022 SHALL drive dout per REQ-010 and REQ-011 during reset, using the reset register values.

Configuration
REQ-023 SHALL support macro MMIO_UART_TX_PARITY_EN as follows:
- Defined: PARITY state is entered after DATA and drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame length is 11 bits.
- Undefined: PARITY state is never entered, DATA goes directly to STOP, and frame length is 10 bits.

Verification
REQ-024 SHALL cover: CLKS_PER_BIT=4, write CTRL=1, write DATA=16'h1255 -> tx shows start 0, bits 1,0,1,0,1,0,1,0, stop 1; each bit lasts 4 cycles; 40 cycles total (44 with MMIO_UART_TX_PARITY_EN defined, parity=0).
REQ-025 SHALL cover: EN=0, write 5 bytes -> STATUS reads 16'h0062 (FULL=1, count=4, OVF=1); write STATUS din=16'h0040 -> STATUS reads 16'h0022.
REQ-026 SHALL cover: EN=1, write 8'hA1 then 8'h3C back-to-back -> two frames with no idle cycle between the first frame's STOP and the second frame's START; after the second STOP, STATUS reads 16'h0004.
REQ-027 SHALL cover: assert rst in the 3rd DATA bit -> tx=1 and STATUS reads 16'h0004 one cycle later; the FIFO content is discarded.
REQ-028 SHALL cover: ren with addr=BASE_ADDR+6 or addr=16'h0000 -> dout=16'h0000, and a wen at either address has no effect on any register.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS/CTRL register window, 4-deep byte FIFO, 8N1 framing.
// Optional even-parity bit when MMIO_UART_TX_PARITY_EN is defined (8E1, 11-bit frame).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line high, waiting for EN=1 and a byte in the FIFO
// S_START  | start bit (tx=0) for CLKS_PER_BIT cycles
// S_DATA   | 8 data bits LSB first, each CLKS_PER_BIT cycles
// S_PARITY | even parity of the byte (only with MMIO_UART_TX_PARITY_EN)
// S_STOP   | stop bit (tx=1); may chain straight into S_START
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter logic [15:0] CLKS_PER_BIT = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic        ren,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        tx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] ADDR_DATA   = BASE_ADDR;
  localparam logic [15:0] ADDR_STATUS = BASE_ADDR + 16'd2;
  localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + 16'd4;
  localparam logic [15:0] RELOAD      = CLKS_PER_BIT - 16'd1;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic [7:0]  mem_q [4];
  logic [7:0]  mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        en_q, en_d;
`ifdef MMIO_UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic hit_data, hit_status, hit_ctrl;
  logic wr_data, empty, full, busy, cnt_tc, pop, push;
  logic [7:0] head;
  logic unused_din;

  assign unused_din = ^din[15:8];

  assign hit_data   = (addr == ADDR_DATA);
  assign hit_status = (addr == ADDR_STATUS);
  assign hit_ctrl   = (addr == ADDR_CTRL);
  assign wr_data    = wen & hit_data;

  assign empty  = (count_q == 3'd0);
  assign full   = (count_q == 3'd4);
  assign busy   = (state_q != S_IDLE);
  assign cnt_tc = (cnt_q == 16'd0);
  assign head   = mem_q[rd_ptr_q];

  // A frame is fetched either from idle or at the last cycle of a stop bit (back-to-back frames).
  assign pop  = en_q & ~empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & cnt_tc));
  assign push = wr_data & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din[7:0];
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    en_d  = en_q;
    if (wr_data & full & ~pop) begin
      ovf_d = 1'b1;
    end else if (wen & hit_status & din[6]) begin
      ovf_d = 1'b0;
    end
    if (wen & hit_ctrl) begin
      en_d = din[0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'd0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      ovf_q     <= 1'b0;
      en_q      <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      en_q      <= en_d;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // FIFO storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Next-state logic, including bit timer and shift register
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
`ifdef MMIO_UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
          cnt_d   = RELOAD;
          shreg_d = head;
`ifdef MMIO_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      S_START: begin
        if (cnt_tc) begin
          state_d   = S_DATA;
          cnt_d     = RELOAD;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_tc) begin
          cnt_d = RELOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PARITY: begin
        if (cnt_tc) begin
          state_d = S_STOP;
          cnt_d   = RELOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_tc) begin
          if (pop) begin
            state_d = S_START;
            cnt_d   = RELOAD;
            shreg_d = head;
`ifdef MMIO_UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Output logic: tx is computed from the next state and registered, so the pin never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`else
      S_PARITY: tx_d = 1'b1;
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

  // While rst is high the read port already reflects the post-reset register values.
  always_comb begin
    dout = 16'h0000;
    if (ren) begin
      if (hit_status) begin
        dout = rst ? 16'h0004 : {9'b0, ovf_q, count_q, empty, full, busy};
      end else if (hit_ctrl) begin
        dout = rst ? 16'h0000 : {15'b0, en_q};
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus random bus traffic,
// compared cycle by cycle against a queue-based model of the FIFO and the serial waveform.
module tb_mmio_uart_tx;

  localparam logic [15:0] BASE     = 16'hFF00;
  localparam logic [15:0] A_DATA   = BASE;
  localparam logic [15:0] A_STATUS = BASE + 16'd2;
  localparam logic [15:0] A_CTRL   = BASE + 16'd4;
  localparam int          N        = 4;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int          NBITS    = 11;
`else
  localparam int          NBITS    = 10;
`endif

  logic        clk = 1'b0;
  logic        rst, wen, ren;
  logic [15:0] addr, din, dout;
  logic        tx;

  always #5 clk = ~clk;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(16'(N))) dut (
    .clk (clk),
    .rst (rst),
    .wen (wen),
    .ren (ren),
    .addr(addr),
    .din (din),
    .dout(dout),
    .tx  (tx)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: pending bytes, and the tx level for every remaining cycle of the current frame.
  logic [7:0] m_fifo[$];
  bit         m_line[$];
  bit         m_ovf, m_en;

  logic [15:0] last_dout;
  logic        last_tx;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input logic r, input logic [15:0] a, input logic rs);
    logic [15:0] v;
    v = 16'h0000;
    if (r && a == A_STATUS) begin
      if (rs) v = 16'h0004;
      else    v = {9'b0, m_ovf, 3'(m_fifo.size()), (m_fifo.size() == 0),
                   (m_fifo.size() == 4), (m_line.size() != 0)};
    end else if (r && a == A_CTRL) begin
      v = rs ? 16'h0000 : {15'b0, m_en};
    end
    return v;
  endfunction

  task automatic m_step(input logic w, input logic [15:0] a, input logic [15:0] d, input logic rs);
    logic [7:0] b;
    bit pop;
    if (rs) begin
      m_fifo.delete();
      m_line.delete();
      m_ovf = 0;
      m_en  = 0;
      return;
    end
    if (m_line.size() != 0) void'(m_line.pop_front());
    pop = (m_line.size() == 0) && m_en && (m_fifo.size() != 0);
    if (pop) begin
      b = m_fifo.pop_front();
      for (int k = 0; k < N; k++) m_line.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < N; k++) m_line.push_back(b[i]);
`ifdef MMIO_UART_TX_PARITY_EN
      for (int k = 0; k < N; k++) m_line.push_back(^b);
`endif
      for (int k = 0; k < N; k++) m_line.push_back(1'b1);
    end
    if (w) begin
      if (a == A_DATA) begin
        if (m_fifo.size() < 4) m_fifo.push_back(d[7:0]);
        else                   m_ovf = 1;
      end else if (a == A_STATUS) begin
        if (d[6]) m_ovf = 0;
      end else if (a == A_CTRL) begin
        m_en = d[0];
      end
    end
  endtask

  task automatic cycle(input logic w, input logic r, input logic [15:0] a,
                       input logic [15:0] d, input logic rs);
    logic exp_tx;
    rst = rs; wen = w; ren = r; addr = a; din = d;
    @(negedge clk);
    exp_tx = (m_line.size() != 0) ? m_line[0] : 1'b1;
    last_tx   = tx;
    last_dout = dout;
    check("tx", {15'b0, tx}, {15'b0, exp_tx});
    check("dout", dout, m_read(r, a, rs));
    @(posedge clk);
    m_step(w, a, d, rs);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cycle(1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a);
    cycle(1'b0, 1'b1, a, 16'h0000, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b1, A_STATUS, 16'h0000, 1'b1);
    check("rst_status_during", last_dout, 16'h0004);
    cycle(1'b1, 1'b1, A_CTRL, 16'h0001, 1'b1);
    check("rst_ctrl_during", last_dout, 16'h0000);
  endtask

  initial begin
    logic [15:0] rand_addr [6];
    logic [7:0]  pat;
    logic        exp_bit;
    int          bi;
    bit          found;

    rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = 16'h0000; din = 16'h0000;
    m_ovf = 0; m_en = 0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    rd(A_STATUS); check("reset_status", last_dout, 16'h0004);
    rd(A_CTRL);   check("reset_ctrl", last_dout, 16'h0000);
    check("reset_tx", {15'b0, last_tx}, 16'h0001);

    // Single frame of 0x55, checked against an explicit bit pattern
    wr(A_CTRL, 16'h0001);
    wr(A_DATA, 16'h1255);
    idle(1);
    pat = 8'h55;
    for (int c = 0; c < NBITS * N; c++) begin
      idle(1);
      bi = c / N;
      if (bi == 0)              exp_bit = 1'b0;
      else if (bi <= 8)         exp_bit = pat[bi-1];
      else if (bi == NBITS - 1) exp_bit = 1'b1;
      else                      exp_bit = ^pat;
      check("frame55_bit", {15'b0, last_tx}, {15'b0, exp_bit});
    end
    rd(A_STATUS); check("frame55_done", last_dout, 16'h0004);
    check("frame55_idle_tx", {15'b0, last_tx}, 16'h0001);

    // FIFO overflow and OVF clear with EN=0
    do_reset();
    for (int i = 0; i < 5; i++) wr(A_DATA, 16'(8'h10 + i));
    rd(A_STATUS); check("ovf_status", last_dout, 16'h0062);
    wr(A_STATUS, 16'h0040);
    rd(A_STATUS); check("ovf_cleared", last_dout, 16'h0022);

    // Back-to-back frames
    do_reset();
    wr(A_CTRL, 16'h0001);
    wr(A_DATA, 16'h00A1);
    wr(A_DATA, 16'h003C);
    idle(2 * NBITS * N + 4);
    rd(A_STATUS); check("b2b_status", last_dout, 16'h0004);

    // Reset in the third data bit discards the frame and the queued byte
    do_reset();
    wr(A_CTRL, 16'h0001);
    wr(A_DATA, 16'h005A);
    wr(A_DATA, 16'h0077);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_line.size() == NBITS * N - 13) found = 1;
      else idle(1);
    end
    check("wait_bit2", {15'b0, found}, 16'h0001);
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    rd(A_STATUS);
    check("midrst_status", last_dout, 16'h0004);
    check("midrst_tx", {15'b0, last_tx}, 16'h0001);
    wr(A_CTRL, 16'h0001);
    idle(8);
    rd(A_STATUS); check("midrst_fifo_gone", last_dout, 16'h0004);

    // Unmapped addresses
    do_reset();
    rd(BASE + 16'd6); check("miss_base6", last_dout, 16'h0000);
    rd(16'h0000);     check("miss_zero", last_dout, 16'h0000);
    wr(BASE + 16'd6, 16'hFFFF);
    wr(16'h0000, 16'hFFFF);
    rd(A_STATUS); check("miss_status", last_dout, 16'h0004);
    rd(A_CTRL);   check("miss_ctrl", last_dout, 16'h0000);

    // Random bus traffic
    rand_addr[0] = A_DATA;
    rand_addr[1] = A_STATUS;
    rand_addr[2] = A_CTRL;
    rand_addr[3] = BASE + 16'd6;
    rand_addr[4] = 16'h0000;
    rand_addr[5] = BASE + 16'd1;
    for (int i = 0; i < 4000; i++) begin
      logic        w, r, rs;
      logic [15:0] a, d;
      w  = ($urandom % 3) == 0;
      r  = ($urandom % 2) == 0;
      a  = rand_addr[$urandom % 6];
      d  = 16'($urandom);
      if (a == A_CTRL) d[0] = ($urandom % 5) != 0;
      rs = ($urandom % 600) == 0;
      cycle(w, r, a, d, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
